udp_tx_buffer: RTL and testbench

Ping-pong payload buffer that sits directly upstream of the UDP/IP frame transmitter. It packs an incoming byte stream into big-endian 32-bit words and fills one of two payload banks while the transmitter reads the other through its word address port. It also supplies the fixed UDP and IP length fields. Banks swap only at frame boundaries, detected from the transmitter's state output.

---
 rtl/udp_tx_buffer.sv | 171 +++++++++++++++++
 tb/tb_udp_tx_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_buffer.sv
// udp_tx_buffer
//   Ping-pong payload buffer feeding the UDP/IP frame transmitter. Incoming
//   bytes are packed big-endian into 32-bit words and written into the write
//   bank while the transmitter reads the other bank by word address. Banks
//   swap only at frame ends, seen as tx_state going 7 -> 0.
//
// Ports
//   clk              system clock, rising edge
//   clr              synchronous active-high reset
//   din/din_valid    payload byte stream, one byte per valid cycle
//   ram_rd_addr      transmitter word read address (payload starts at 1)
//   tx_state         transmitter state (7 = CRC, 0 = idle)
//   datain           registered word read from the read bank
//   tx_data_length   UDP length, 8 + 4*PAYLOAD_WORDS
//   tx_total_length  IP total length, 28 + 4*PAYLOAD_WORDS
//   frame_ready      read bank holds a complete payload
//   drop_cnt         bytes discarded while both banks were full (saturating)
//   underrun_cnt     frame ends seen without a ready payload (saturating)
//
// Writer FSM
//   state      | meaning
//   WR_FILL    | accepting bytes into wr_bank
//   WR_BLOCKED | both banks full, incoming bytes dropped
module udp_tx_buffer #(
  parameter int PAYLOAD_WORDS = 256
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic [8:0]  ram_rd_addr,
  input  logic [3:0]  tx_state,
  output logic [31:0] datain,
  output logic [15:0] tx_data_length,
  output logic [15:0] tx_total_length,
  output logic        frame_ready,
  output logic [15:0] drop_cnt,
  output logic [15:0] underrun_cnt
);

  typedef enum logic {WR_FILL = 1'b0, WR_BLOCKED = 1'b1} wr_state_e;

  localparam logic [8:0]  LAST_ADDR = 9'(PAYLOAD_WORDS);
  localparam logic [15:0] DATA_LEN  = 16'(8 + 4 * PAYLOAD_WORDS);
  localparam logic [15:0] TOTAL_LEN = 16'(28 + 4 * PAYLOAD_WORDS);

  wr_state_e   wr_state_q, wr_state_d;
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [1:0]  full_q, full_d, full_rel;
  logic [8:0]  wr_addr_q, wr_addr_d;
  logic [1:0]  lane_q, lane_d;
  logic [23:0] acc_q, acc_d;
  logic [3:0]  prev_state_q;
  logic [15:0] drop_cnt_q, underrun_cnt_q;
  logic [15:0] data_len_q, total_len_q;
  logic [31:0] datain_q;

  logic        end_evt, release_rd, accept, drop, word_we, last_word;
  logic [31:0] word;

  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];

  assign end_evt     = (prev_state_q == 4'd7) && (tx_state == 4'd0);
  assign frame_ready = full_q[rd_bank_q];
  assign release_rd  = end_evt && frame_ready;
  assign word        = {acc_q, din};
  assign word_we     = accept && (lane_q == 2'd3);
  assign last_word   = word_we && (wr_addr_q == LAST_ADDR);

  // Full flags with this cycle's release already applied, so a fill that
  // coincides with a release sees the other bank as free.
  always_comb begin
    full_rel = full_q;
    if (release_rd) full_rel[rd_bank_q] = 1'b0;
  end

  always_comb begin
    accept = 1'b0;
    drop   = 1'b0;
    case (wr_state_q)
      WR_FILL:    accept = din_valid;
      WR_BLOCKED: drop   = din_valid;
      default:    ;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_FILL:    if (last_word && full_rel[~wr_bank_q]) wr_state_d = WR_BLOCKED;
      WR_BLOCKED: if (!full_q[~wr_bank_q]) wr_state_d = WR_FILL;
      default:    wr_state_d = WR_FILL;
    endcase
  end

  always_comb begin
    full_d    = full_rel;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_addr_d = wr_addr_q;
    lane_d    = lane_q;
    acc_d     = acc_q;
    if (release_rd) rd_bank_d = ~rd_bank_q;
    if (accept) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    acc_d[23:16] = din;
        2'd1:    acc_d[15:8]  = din;
        2'd2:    acc_d[7:0]   = din;
        default: ;
      endcase
    end
    if (word_we) wr_addr_d = last_word ? 9'd1 : wr_addr_q + 9'd1;
    if (last_word) begin
      full_d[wr_bank_q] = 1'b1;
      if (!full_rel[~wr_bank_q]) wr_bank_d = ~wr_bank_q;
    end
    if (wr_state_q == WR_BLOCKED && !full_q[~wr_bank_q]) wr_bank_d = ~wr_bank_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_state_q     <= WR_FILL;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      full_q         <= 2'b00;
      wr_addr_q      <= 9'd1;
      lane_q         <= 2'd0;
      acc_q          <= 24'd0;
      prev_state_q   <= 4'd0;
      drop_cnt_q     <= 16'd0;
      underrun_cnt_q <= 16'd0;
      data_len_q     <= DATA_LEN;
      total_len_q    <= TOTAL_LEN;
    end else begin
      wr_state_q   <= wr_state_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      full_q       <= full_d;
      wr_addr_q    <= wr_addr_d;
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      prev_state_q <= tx_state;
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (end_evt && !frame_ready && underrun_cnt_q != 16'hFFFF)
        underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (word_we && !clr) begin
      if (wr_bank_q) mem1[wr_addr_q] <= word;
      else           mem0[wr_addr_q] <= word;
    end
  end

  always_ff @(posedge clk) begin
    if (clr || ram_rd_addr == 9'd0) datain_q <= 32'd0;
    else if (rd_bank_q)             datain_q <= mem1[ram_rd_addr];
    else                            datain_q <= mem0[ram_rd_addr];
  end

  assign datain          = datain_q;
  assign tx_data_length  = data_len_q;
  assign tx_total_length = total_len_q;
  assign drop_cnt        = drop_cnt_q;
  assign underrun_cnt    = underrun_cnt_q;

endmodule

// File: tb/tb_udp_tx_buffer.sv
module tb_udp_tx_buffer;

  localparam int PW = 4;

  localparam int K_READY = 0;
  localparam int K_DROP  = 1;
  localparam int K_UNDER = 2;
  localparam int K_DATA  = 3;
  localparam int K_DLEN  = 4;
  localparam int K_TLEN  = 5;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [7:0]  din = 8'd0;
  logic        din_valid = 1'b0;
  logic [8:0]  ram_rd_addr = 9'd0;
  logic [3:0]  tx_state = 4'd0;
  logic [31:0] datain;
  logic [15:0] tx_data_length, tx_total_length, drop_cnt, underrun_cnt;
  logic        frame_ready;

  item_t rdq[$];
  item_t stq[$];
  logic  rd_v = 1'b0;
  logic  rd_v_d = 1'b0;
  logic  st_v = 1'b0;
  int    checks = 0;
  int    failures = 0;

  udp_tx_buffer #(.PAYLOAD_WORDS(PW)) dut (
    .clk(clk), .clr(clr), .din(din), .din_valid(din_valid),
    .ram_rd_addr(ram_rd_addr), .tx_state(tx_state), .datain(datain),
    .tx_data_length(tx_data_length), .tx_total_length(tx_total_length),
    .frame_ready(frame_ready), .drop_cnt(drop_cnt), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_v_d <= rd_v;

  // Monitor: pops expectations whenever a read result or status sample is due.
  always @(negedge clk) begin
    item_t       it;
    logic [31:0] act;
    if (rd_v_d) begin
      checks++;
      if (rdq.size() == 0) begin
        failures++;
        $display("FAIL rd_queue_empty actual=%h", datain);
      end else begin
        it = rdq.pop_front();
        if (datain !== it.exp) begin
          failures++;
          $display("FAIL %s actual=%h expected=%h", it.name, datain, it.exp);
        end
      end
    end
    if (st_v) begin
      checks++;
      if (stq.size() == 0) begin
        failures++;
        $display("FAIL st_queue_empty");
      end else begin
        it = stq.pop_front();
        case (it.kind)
          K_READY: act = {31'd0, frame_ready};
          K_DROP:  act = {16'd0, drop_cnt};
          K_UNDER: act = {16'd0, underrun_cnt};
          K_DATA:  act = datain;
          K_DLEN:  act = {16'd0, tx_data_length};
          default: act = {16'd0, tx_total_length};
        endcase
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s actual=%h expected=%h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input logic [31:0] exp, input string name);
    item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    stq.push_back(it);
    st_v = 1'b1;
    @(negedge clk);
    #1;
    st_v = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [8:0] addr, input logic [31:0] exp, input string name);
    item_t it;
    it.kind = K_DATA;
    it.exp  = exp;
    it.name = name;
    rdq.push_back(it);
    ram_rd_addr = addr;
    rd_v = 1'b1;
    tick();
    rd_v = 1'b0;
  endtask

  task automatic send(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      din = start + 8'(i);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic frame_end();
    tx_state = 4'd7;
    tick();
    tx_state = 4'd0;
    tick();
    tick();
    tick();
  endtask

  task automatic reset_checks(input string tag);
    chk(K_READY, 32'd0, {tag, "_ready"});
    chk(K_DROP,  32'd0, {tag, "_drop"});
    chk(K_UNDER, 32'd0, {tag, "_under"});
    chk(K_DATA,  32'd0, {tag, "_datain"});
    chk(K_DLEN,  32'd24, {tag, "_dlen"});
    chk(K_TLEN,  32'd44, {tag, "_tlen"});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1;
    tick();
    reset_checks("rst");
    clr = 1'b0;
    tick();

    // First frame into bank 0
    send(8'h00, 15);
    chk(K_READY, 32'd0, "ready_before_last");
    send(8'h0F, 1);
    chk(K_READY, 32'd1, "ready_after_last");
    rd(9'd1, 32'h00010203, "f0_w1");
    rd(9'd2, 32'h04050607, "f0_w2");
    rd(9'd3, 32'h08090A0B, "f0_w3");
    rd(9'd4, 32'h0C0D0E0F, "f0_w4");
    rd(9'd0, 32'h00000000, "f0_addr0");

    // Second frame fills bank 1, then swap
    send(8'h10, 16);
    frame_end();
    chk(K_READY, 32'd1, "ready_after_swap");
    rd(9'd1, 32'h10111213, "f1_w1");
    rd(9'd4, 32'h1C1D1E1F, "f1_w4");
    chk(K_DROP, 32'd0, "drop_none");

    // Overflow: bank 0 fills, 16 more bytes dropped
    send(8'h20, 16);
    send(8'h30, 16);
    chk(K_DROP, 32'd16, "drop_16");
    frame_end();
    chk(K_READY, 32'd1, "ready_f2");
    rd(9'd1, 32'h20212223, "f2_w1");
    rd(9'd4, 32'h2C2D2E2F, "f2_w4");
    send(8'h40, 16);
    frame_end();
    rd(9'd1, 32'h40414243, "resume_w1");
    rd(9'd4, 32'h4C4D4E4F, "resume_w4");

    // Bank 0 fill coincides with release of bank 1
    send(8'h50, 15);
    tx_state = 4'd7;
    tick();
    tx_state = 4'd0;
    din = 8'h5F;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    send(8'h60, 16);
    chk(K_DROP, 32'd16, "coincide_drop");
    chk(K_READY, 32'd1, "coincide_ready");
    rd(9'd1, 32'h50515253, "f5_w1");
    rd(9'd4, 32'h5C5D5E5F, "f5_w4");
    frame_end();
    rd(9'd1, 32'h60616263, "coincide_w1");
    rd(9'd4, 32'h6C6D6E6F, "coincide_w4");

    // Drain, then underrun
    frame_end();
    chk(K_READY, 32'd0, "drained_ready");
    chk(K_UNDER, 32'd0, "under_zero");
    frame_end();
    chk(K_UNDER, 32'd1, "under_one");
    chk(K_READY, 32'd0, "under_ready");

    // Mid-frame clr
    send(8'h70, 6);
    clr = 1'b1;
    tick();
    reset_checks("clr");
    clr = 1'b0;
    tick();
    frame_end();
    chk(K_UNDER, 32'd1, "clr_under");
    send(8'h80, 16);
    chk(K_READY, 32'd1, "clr_ready");
    rd(9'd1, 32'h80818283, "clr_w1");
    rd(9'd2, 32'h84858687, "clr_w2");
    rd(9'd3, 32'h88898A8B, "clr_w3");
    rd(9'd4, 32'h8C8D8E8F, "clr_w4");

    for (int i = 0; i < 10 && (rdq.size() != 0 || stq.size() != 0); i++) tick();
    if (rdq.size() != 0 || stq.size() != 0) begin
      failures++;
      $display("FAIL queue_drain pending=%0d expected=0", rdq.size() + stq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
